// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
//
// Load/store unit of the MEM stage of a 5-stage RV32I pipeline. Sits between
// the EX/MEM pipeline register and the data-cache port and feeds the MEM/WB
// register. Each memory instruction issues exactly one cache request. The
// pipeline is held until the response arrives, or until the wait watchdog
// expires. Load results leave this block already byte/half selected and
// sign- or zero-extended. Misaligned accesses complete immediately with a flag
// and never reach the cache.
//
// Parameters
//   MAX_WAIT      ACCESS cycles without data_resp before bus_err (0 = off)
//
// Ports
//   clk, rst_n    clock, synchronous active-low reset
//   req_valid     EX/MEM holds a valid memory instruction
//   req_load      1 = load, 0 = store
//   load_sel      regfilemux select: lw=0011 lb=0101 lbu=0110 lh=0111 lhu=1000
//   store_funct3  000=sb 001=sh 010=sw
//   req_addr      effective address
//   req_wdata     rs2 value
//   data_read     cache read strobe
//   data_write    cache write strobe
//   data_addr     word-aligned cache address
//   data_mbe      cache byte enables
//   data_wdata    store data replicated onto its byte lanes
//   data_resp     cache completion pulse
//   data_rdata    cache read data, valid with data_resp
//   stall         freeze IF..MEM
//   done          one-cycle completion pulse
//   load_data     formatted load result, held until the next capture
//   misaligned    access was misaligned, valid with done
//   bus_err       cache watchdog expired, valid with done
// ---------------------------------------------------------------------------
module mem_stage_lsu #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic [3:0]  load_sel,
  input  logic [2:0]  store_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_addr,
  output logic [3:0]  data_mbe,
  output logic [31:0] data_wdata,
  input  logic        data_resp,
  input  logic [31:0] data_rdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err
);

  // regfilemux select encodings for the load flavours
  localparam logic [3:0] SEL_LB  = 4'b0101;
  localparam logic [3:0] SEL_LBU = 4'b0110;
  localparam logic [3:0] SEL_LH  = 4'b0111;
  localparam logic [3:0] SEL_LHU = 4'b1000;

  // store funct3 encodings (anything else behaves as sw)
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;

  // Watchdog counter just wide enough to hold MAX_WAIT
  localparam bit               WDOG_EN   = (MAX_WAIT != 0);
  localparam int unsigned      CNT_W     = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_e           state_q,      state_d;
  logic             data_read_q,  data_read_d;
  logic             data_write_q, data_write_d;
  logic [31:0]      data_addr_q,  data_addr_d;
  logic [3:0]       data_mbe_q,   data_mbe_d;
  logic [31:0]      data_wdata_q, data_wdata_d;
  logic [31:0]      load_data_q,  load_data_d;
  logic             misaligned_q, misaligned_d;
  logic             bus_err_q,    bus_err_d;
  logic             done_q,       done_d;
  logic [CNT_W-1:0] wait_cnt_q,   wait_cnt_d;

  // Load formatting context latched at acceptance, so the EX/MEM register is
  // free to change while the cache is busy.
  size_e            size_q,       size_d;
  logic             sext_q,       sext_d;
  logic [1:0]       off_q,        off_d;

  // -------------------------------------------------------------------------
  // Request decode (from the live EX/MEM inputs)
  // -------------------------------------------------------------------------
  size_e       req_size;
  logic        req_sext;
  logic        req_misaligned;
  logic [1:0]  req_off;
  logic [3:0]  req_mbe;
  logic [31:0] req_lane_wdata;

  assign req_off = req_addr[1:0];

  // NOTE: every signal written in an always_comb gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    req_size = SZ_WORD;
    req_sext = 1'b0;
    if (req_load) begin
      case (load_sel)
        SEL_LB:  begin req_size = SZ_BYTE; req_sext = 1'b1; end
        SEL_LBU: begin req_size = SZ_BYTE; req_sext = 1'b0; end
        SEL_LH:  begin req_size = SZ_HALF; req_sext = 1'b1; end
        SEL_LHU: begin req_size = SZ_HALF; req_sext = 1'b0; end
        default: begin req_size = SZ_WORD; req_sext = 1'b0; end
      endcase
    end else begin
      case (store_funct3)
        F3_SB:   req_size = SZ_BYTE;
        F3_SH:   req_size = SZ_HALF;
        default: req_size = SZ_WORD;
      endcase
    end
  end

  // Byte accesses can never be misaligned.
  always_comb begin
    case (req_size)
      SZ_HALF: req_misaligned = req_off[0];
      SZ_WORD: req_misaligned = |req_off;
      default: req_misaligned = 1'b0;
    endcase
  end

  // Store lane placement: the data is replicated across the word so the
  // byte enables alone select the lane. Loads always read the full word.
  always_comb begin
    req_mbe        = 4'b1111;
    req_lane_wdata = req_wdata;
    if (!req_load) begin
      case (req_size)
        SZ_BYTE: begin
          req_mbe        = 4'b0001 << req_off;
          req_lane_wdata = {4{req_wdata[7:0]}};
        end
        SZ_HALF: begin
          req_mbe        = 4'b0011 << req_off;
          req_lane_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          req_mbe        = 4'b1111;
          req_lane_wdata = req_wdata;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Load formatting (from the cache data and the latched context)
  // -------------------------------------------------------------------------
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_fmt;

  always_comb begin
    rd_byte = data_rdata[{off_q, 3'b000} +: 8];
    rd_half = data_rdata[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      SZ_BYTE: rd_fmt = {{24{sext_q & rd_byte[7]}}, rd_byte};
      SZ_HALF: rd_fmt = {{16{sext_q & rd_half[15]}}, rd_half};
      default: rd_fmt = data_rdata;
    endcase
  end

  // The counter holds the number of ACCESS cycles already spent, so the
  // current cycle is the last one allowed when counter+1 reaches the limit.
  logic timeout;
  assign timeout = WDOG_EN && ((wait_cnt_q + CNT_ONE) == CNT_LIMIT);

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    data_read_d  = data_read_q;
    data_write_d = data_write_q;
    data_addr_d  = data_addr_q;
    data_mbe_d   = data_mbe_q;
    data_wdata_d = data_wdata_q;
    load_data_d  = load_data_q;
    misaligned_d = misaligned_q;
    bus_err_d    = bus_err_q;
    done_d       = 1'b0;
    wait_cnt_d   = wait_cnt_q;
    size_d       = size_q;
    sext_d       = sext_q;
    off_d        = off_q;
    stall        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          if (req_misaligned) begin
            // Completes immediately; the cache never sees this access.
            state_d      = ST_DONE;
            misaligned_d = 1'b1;
            done_d       = 1'b1;
          end else begin
            state_d      = ST_ACCESS;
            data_read_d  = req_load;
            data_write_d = !req_load;
            data_addr_d  = {req_addr[31:2], 2'b00};
            data_mbe_d   = req_mbe;
            data_wdata_d = req_load ? 32'h0 : req_lane_wdata;
            size_d       = req_size;
            sext_d       = req_sext;
            off_d        = req_off;
            wait_cnt_d   = '0;
          end
        end
      end

      ST_ACCESS: begin
        stall = 1'b1;
        // A response in the watchdog's final cycle still counts as success.
        if (data_resp) begin
          if (data_read_q) begin
            load_data_d = rd_fmt;
          end
          data_read_d  = 1'b0;
          data_write_d = 1'b0;
          state_d      = ST_DONE;
          done_d       = 1'b1;
        end else if (timeout) begin
          data_read_d  = 1'b0;
          data_write_d = 1'b0;
          bus_err_d    = 1'b1;
          load_data_d  = 32'h0;
          state_d      = ST_DONE;
          done_d       = 1'b1;
        end else if (WDOG_EN) begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
      end

      ST_DONE: begin
        // req_valid here still belongs to the completing instruction, so
        // it is deliberately ignored and the FSM always returns to IDLE.
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        wait_cnt_d   = '0;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      data_read_q  <= 1'b0;
      data_write_q <= 1'b0;
      data_addr_q  <= 32'h0;
      data_mbe_q   <= 4'h0;
      data_wdata_q <= 32'h0;
      load_data_q  <= 32'h0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      done_q       <= 1'b0;
      wait_cnt_q   <= '0;
      size_q       <= SZ_WORD;
      sext_q       <= 1'b0;
      off_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      data_read_q  <= data_read_d;
      data_write_q <= data_write_d;
      data_addr_q  <= data_addr_d;
      data_mbe_q   <= data_mbe_d;
      data_wdata_q <= data_wdata_d;
      load_data_q  <= load_data_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
      done_q       <= done_d;
      wait_cnt_q   <= wait_cnt_d;
      size_q       <= size_d;
      sext_q       <= sext_d;
      off_q        <= off_d;
    end
  end

  assign data_read  = data_read_q;
  assign data_write = data_write_q;
  assign data_addr  = data_addr_q;
  assign data_mbe   = data_mbe_q;
  assign data_wdata = data_wdata_q;
  assign load_data  = load_data_q;
  assign misaligned = misaligned_q;
  assign bus_err    = bus_err_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_lsu
//
// Self-checking bench for mem_stage_lsu. Directed steps followed by random
// transactions. Expected values come from an arithmetic model of the RV32I
// access rules (size in bytes, offset within the word, sign extension by
// value range). Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_stage_lsu;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_load;
  logic [3:0]  load_sel;
  logic [2:0]  store_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [3:0]  data_mbe;
  logic [31:0] data_wdata;
  logic        data_resp;
  logic [31:0] data_rdata;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_stage_lsu #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_load     (req_load),
    .load_sel     (load_sel),
    .store_funct3 (store_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .data_read    (data_read),
    .data_write   (data_write),
    .data_addr    (data_addr),
    .data_mbe     (data_mbe),
    .data_wdata   (data_wdata),
    .data_resp    (data_resp),
    .data_rdata   (data_rdata),
    .stall        (stall),
    .done         (done),
    .load_data    (load_data),
    .misaligned   (misaligned),
    .bus_err      (bus_err)
  );

  typedef enum int {
    OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LX,
    OP_SB, OP_SH, OP_SW, OP_SX
  } op_e;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_load_data = 32'h0;

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  function automatic bit op_is_load(input op_e op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
           (op == OP_LH) || (op == OP_LHU) || (op == OP_LX);
  endfunction

  // Access width in bytes; undefined encodings behave as words.
  function automatic int op_size(input op_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      default:              return 4;
    endcase
  endfunction

  function automatic bit op_signed(input op_e op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic logic [3:0] op_sel(input op_e op);
    case (op)
      OP_LW:   return 4'b0011;
      OP_LB:   return 4'b0101;
      OP_LBU:  return 4'b0110;
      OP_LH:   return 4'b0111;
      OP_LHU:  return 4'b1000;
      OP_LX:   return 4'b0000;
      default: return 4'b0011;
    endcase
  endfunction

  function automatic logic [2:0] op_f3(input op_e op);
    case (op)
      OP_SB:   return 3'b000;
      OP_SH:   return 3'b001;
      OP_SW:   return 3'b010;
      OP_SX:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [3:0] model_mbe(input op_e op, input logic [31:0] addr);
    logic [3:0] m;
    int off;
    int sz;
    m   = 4'b0000;
    off = int'(addr[1:0]);
    sz  = op_size(op);
    if (op_is_load(op)) return 4'b1111;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + sz) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [31:0] model_wdata(input op_e op, input logic [31:0] rs2);
    logic [31:0] w;
    int sz;
    sz = op_size(op);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input op_e op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    longint v;
    longint span;
    int sz;
    sz   = op_size(op);
    span = longint'(1) << (8 * sz);
    v    = (longint'(rdata) >> (8 * int'(addr[1:0]))) % span;
    if (op_signed(op) && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete memory instruction, starting and ending on a falling edge
  // with the DUT idle. resp_at is the ACCESS cycle (1-based) in which
  // data_resp pulses; 0 or anything beyond MAX_WAIT means no response.
  task automatic run_txn(input string name, input op_e op, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [31:0] rdata, input int resp_at);
    bit ld;
    bit mis;
    bit tmo;
    int last;
    ld   = op_is_load(op);
    mis  = (int'(addr[1:0]) % op_size(op)) != 0;
    tmo  = (resp_at == 0) || (resp_at > MAX_WAIT);
    last = tmo ? MAX_WAIT : resp_at;

    req_valid    = 1'b1;
    req_load     = ld;
    load_sel     = op_sel(op);
    store_funct3 = op_f3(op);
    req_addr     = addr;
    req_wdata    = rs2;
    #1 check({name, " stall on request"}, stall, 1'b1);
    @(negedge clk);

    if (!mis) begin
      for (int k = 1; k <= last; k++) begin
        check({name, " data_read"},  data_read,  ld);
        check({name, " data_write"}, data_write, !ld);
        check({name, " access stall"}, stall, 1'b1);
        check({name, " access done"},  done,  1'b0);
        check({name, " data_addr"}, data_addr, addr & 32'hFFFF_FFFC);
        check({name, " data_mbe"},  data_mbe,  model_mbe(op, addr));
        if (!ld) check({name, " data_wdata"}, data_wdata, model_wdata(op, rs2));
        if (k == resp_at) begin
          data_resp  = 1'b1;
          data_rdata = rdata;
        end
        @(negedge clk);
        data_resp  = 1'b0;
        data_rdata = $urandom;
      end
      if (tmo) exp_load_data = 32'h0;
      else if (ld) exp_load_data = model_load(op, addr, rdata);
    end

    check({name, " done pulse"},  done, 1'b1);
    check({name, " done stall"},  stall, 1'b0);
    check({name, " misaligned"},  misaligned, mis);
    check({name, " bus_err"},     bus_err, !mis && tmo);
    check({name, " strobe off"},  {data_read, data_write}, 2'b00);
    check({name, " load_data"},   load_data, exp_load_data);

    // req_valid stays high through DONE and must not start a new access.
    @(negedge clk);
    req_valid = 1'b0;
    check({name, " done low"},      done, 1'b0);
    check({name, " flags cleared"}, {misaligned, bus_err}, 2'b00);
    check({name, " no reaccept"},   {data_read, data_write}, 2'b00);
    check({name, " load_data held"}, load_data, exp_load_data);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_load     = 1'b0;
    load_sel     = 4'b0000;
    store_funct3 = 3'b000;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    data_resp    = 1'b0;
    data_rdata   = 32'h0;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset data_read",  data_read,  1'b0);
    check("reset data_write", data_write, 1'b0);
    check("reset data_addr",  data_addr,  32'h0);
    check("reset data_mbe",   data_mbe,   4'h0);
    check("reset data_wdata", data_wdata, 32'h0);
    check("reset load_data",  load_data,  32'h0);
    check("reset flags",      {misaligned, bus_err, done}, 3'b000);
    check("reset stall",      stall, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_txn("lw",      OP_LW,  32'h1000_0004, 32'h0,         32'hDEAD_BEEF, 2);
    run_txn("lb",      OP_LB,  32'h2000_0003, 32'h0,         32'h80FF_0000, 1);
    run_txn("lbu",     OP_LBU, 32'h2000_0003, 32'h0,         32'h80FF_0000, 1);
    run_txn("lh",      OP_LH,  32'h2000_0002, 32'h0,         32'h8001_1234, 3);
    run_txn("lhu",     OP_LHU, 32'h2000_0002, 32'h0,         32'h8001_1234, 1);
    run_txn("sb",      OP_SB,  32'h2000_0001, 32'h0000_00AB, 32'h0,         1);
    run_txn("sh",      OP_SH,  32'h2000_0002, 32'h0000_1234, 32'h0,         2);
    run_txn("sw",      OP_SW,  32'h2000_0008, 32'hCAFE_F00D, 32'h0,         1);
    run_txn("lw mis",  OP_LW,  32'h2000_0002, 32'h0,         32'h0,         1);
    run_txn("lh mis",  OP_LH,  32'h2000_0001, 32'h0,         32'h0,         1);
    run_txn("sh mis",  OP_SH,  32'h2000_0003, 32'h1111_2222, 32'h0,         1);
    run_txn("sw mis",  OP_SW,  32'h2000_0001, 32'h1111_2222, 32'h0,         1);
    run_txn("lx word", OP_LX,  32'h2000_000C, 32'h0,         32'h1357_9BDF, 1);
    run_txn("sx word", OP_SX,  32'h2000_0010, 32'h2468_ACE0, 32'h0,         1);
    run_txn("timeout", OP_LW,  32'h3000_0000, 32'h0,         32'h0,         0);
    run_txn("lw last", OP_LW,  32'h3000_0004, 32'h0,         32'h7654_3210, MAX_WAIT);
    run_txn("sb tmo",  OP_SB,  32'h3000_0006, 32'h0000_005A, 32'h0,         0);

    // Reset in the middle of an ACCESS, then a stray late response
    run_txn("lb pre",  OP_LB,  32'h3000_0001, 32'h0,         32'h0000_7F00, 1);
    req_valid    = 1'b1;
    req_load     = 1'b1;
    load_sel     = 4'b0011;
    store_funct3 = 3'b010;
    req_addr     = 32'h3000_0008;
    @(negedge clk);
    check("midrst strobe up", data_read, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    exp_load_data = 32'h0;
    check("midrst strobe dropped", data_read, 1'b0);
    check("midrst done",           done, 1'b0);
    check("midrst load_data",      load_data, exp_load_data);
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    data_resp  = 1'b1;
    data_rdata = 32'h1234_5678;
    @(negedge clk);
    data_resp = 1'b0;
    check("late resp done",      done, 1'b0);
    check("late resp strobe",    {data_read, data_write}, 2'b00);
    check("late resp load_data", load_data, exp_load_data);
    check("late resp idle stall", stall, 1'b0);
    @(negedge clk);
    check("late resp done later", done, 1'b0);
    run_txn("lhu post", OP_LHU, 32'h3000_0000, 32'h0, 32'hABCD_9876, 2);

    // Random transactions
    for (int n = 0; n < 40; n++) begin
      op_e         op;
      logic [31:0] addr;
      int          resp_at;
      op      = op_e'($urandom_range(0, 9));
      addr    = $urandom;
      resp_at = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, MAX_WAIT));
      run_txn($sformatf("rand%0d", n), op, addr, $urandom, $urandom, resp_at);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit of the MEM stage in the 5-stage RV32I pipeline.
- Sits between the EX/MEM pipeline register and the data cache port, and feeds the MEM/WB register.
- Issues one cache request per memory instruction and holds the pipeline until the response arrives.
- Produces load data already byte-selected and sign- or zero-extended according to the regfilemux select (lw/lb/lbu/lh/lhu), and flags misaligned accesses.

Parameters:
- MAX_WAIT, 255, cycles spent in ACCESS without data_resp before bus_err is raised; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  EX/MEM holds a valid memory instruction.
- req_load  in  1  1 = load, 0 = store; meaningful only when req_valid=1.
- load_sel  in  4  regfilemux_sel_t encoding: lw=0011, lb=0101, lbu=0110, lh=0111, lhu=1000.
- store_funct3  in  3  000=sb, 001=sh, 010=sw.
- req_addr  in  32  effective address (alu_out).
- req_wdata  in  32  rs2 value.
- data_read  out  1  cache read strobe.
- data_write  out  1  cache write strobe.
- data_addr  out  32  {req_addr[31:2], 2'b00}.
- data_mbe  out  4  byte enables.
- data_wdata  out  32  store data shifted to its byte lane.
- data_resp  in  1  cache completion, one-cycle pulse.
- data_rdata  in  32  cache read data, valid with data_resp.
- stall  out  1  freeze IF..MEM stages.
- done  out  1  one-cycle pulse: result valid, pipeline may advance.
- load_data  out  32  formatted load result.
- misaligned  out  1  valid with done.
- bus_err  out  1  valid with done.

Behaviour:
- States: IDLE, ACCESS, DONE.
- Reset (rst_n=0 at a clk edge): state=IDLE; all registered outputs 0 (data_read, data_write, data_addr, data_mbe, data_wdata, load_data, misaligned, bus_err, done); wait counter=0.
- Reset mid-ACCESS drops data_read/data_write on the next cycle. A data_resp that arrives after reset is ignored.
- IDLE:
  - stall = req_valid (combinational).
  - req_valid and aligned: latch address, masks, data and load_sel; go to ACCESS. data_read (load) or data_write (store) is asserted from the next cycle.
  - req_valid and misaligned: go to DONE with misaligned=1; no cache strobe is ever raised.
- Alignment rules:
  - lh, lhu, sh are misaligned when addr[0]=1.
  - lw, sw are misaligned when addr[1:0]≠0.
  - Byte accesses are never misaligned.
- ACCESS:
  - stall=1. Strobe, data_addr, data_mbe and data_wdata are held stable.
  - On data_resp: capture formatted load_data (loads only), drop the strobe, go to DONE.
  - Counter increments each ACCESS cycle. When it reaches MAX_WAIT (MAX_WAIT≠0): drop the strobe, bus_err=1, load_data=0, go to DONE.
  - data_resp and timeout in the same cycle: data_resp wins, bus_err=0.
- DONE:
  - stall=0, done=1 for exactly one cycle; go to IDLE.
  - req_valid in this cycle belongs to the completing instruction and is not re-accepted.
  - misaligned and bus_err clear on leaving DONE. load_data holds until the next capture.
- Latency: request accepted at cycle 0, strobe at cycle 1, earliest data_resp at cycle 1, done at cycle 2. Each extra cache wait cycle adds 1.
- Store lane placement, with o = addr[1:0]:
  - sb: mbe = 0001<<o, wdata = {4{rs2[7:0]}}.
  - sh: mbe = 0011<<o, wdata = {2{rs2[15:0]}}.
  - sw: mbe = 1111, wdata = rs2.
- Load formatting:
  - lb/lbu: byte = rdata[8*o+7 : 8*o].
  - lh/lhu: half = rdata[16*o[1]+15 : 16*o[1]].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes rdata unchanged.
- Load data_mbe is 1111.
- Undefined load_sel or store_funct3: treat as a word access.

Test Plan:
- lw at 0x1000_0004, data_resp 2 cycles after strobe with rdata=0xDEADBEEF → data_read held 2 cycles, data_addr=0x1000_0004, stall high until done, load_data=0xDEADBEEF.
- lb/lbu at 0x...03 with rdata=0x80FF_0000 → lb gives 0xFFFF_FF80; lbu gives 0x0000_0080.
- lh at 0x...02 with rdata=0x8001_1234 → 0xFFFF_8001; lhu at the same address → 0x0000_8001.
- sb at 0x...01, rs2=0x0000_00AB → data_write, mbe=0010, wdata=0xABAB_ABAB. sh at 0x...02, rs2=0x1234 → mbe=1100.
- lw at 0x...02 → no strobe ever raised, done next cycle with misaligned=1, stall high exactly 1 cycle.
- MAX_WAIT=4, no data_resp → strobe drops after 4 ACCESS cycles, done with bus_err=1. Separately, rst_n=0 mid-ACCESS → strobe low next cycle, state IDLE, and a late data_resp is ignored.
